uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive buffer between the uart_rx instance and mem_ctl's UART register window. It captures each byte that uart_rx delivers and queues it in a DEPTH-entry FIFO. mem_ctl pops the queue through a show-ahead read port. The block also keeps sticky overflow/break status and drives a level interrupt for software polling or IRQ use.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
LOG2_DEPTH, 4, log2(DEPTH); pointer width
IRQ_THRESHOLD, 1, irq asserts when count >= this value; range 1..DEPTH

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
enable  input  1  receiver enable from UART control register
uart_rx_en  output  1  enable to uart_rx; combinational copy of enable
uart_rx_valid  input  1  one-cycle pulse per received byte
uart_rx_data  input  8  received byte; valid while uart_rx_valid = 1
uart_rx_break  input  1  one-cycle pulse on line break
pop  input  1  mem_ctl read strobe; removes head entry
flush  input  1  discards all queued bytes
clr_flags  input  1  clears overflow and break_seen
rd_data  output  8  head byte (show-ahead); 8'h00 when empty
rd_valid  output  1  FIFO non-empty
full  output  1  count == DEPTH
count  output  LOG2_DEPTH+1  number of queued bytes, 0..DEPTH
overflow  output  1  sticky: a byte was dropped because the FIFO was full
break_seen  output  1  sticky: a break was received
irq  output  1  (count >= IRQ_THRESHOLD) | overflow

Behaviour:
- All state updates on rising clk. Reset applies when rst_n = 0 at a clk edge; reset is synchronous only.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0, break_seen = 0. As a result rd_valid = 0, full = 0, rd_data = 8'h00, irq = 0. Storage array contents are not reset.
- Reset mid-operation empties the FIFO immediately. Bytes in flight are lost. No flags are set.
- Push condition: uart_rx_valid & enable & ~uart_rx_break & ~flush.
- When uart_rx_valid and uart_rx_break coincide, the byte is discarded, break_seen is set, and overflow is unchanged.
- enable = 0: uart_rx_valid is ignored. Queued data stays poppable.
- Pop is effective only when count != 0. A pop on empty is ignored: no pointer move, no flag.
- Latency: a byte pushed at edge N appears on rd_data/rd_valid after edge N (combinational from registered state). A pop at edge N exposes the next entry after edge N.
- Push with count < DEPTH: mem[wr_ptr] <= data, wr_ptr++, count++.
- Push with full and no pop: byte dropped, overflow <= 1, state unchanged.
- Push with full and pop in the same cycle: the pop frees a slot, the byte is accepted, count stays DEPTH, overflow is not set.
- Push and pop on empty in the same cycle: the push is accepted, the pop is ignored, count becomes 1.
- Push and pop with 0 < count < DEPTH: both happen, count unchanged.
- Pointers are LOG2_DEPTH bits and wrap modulo DEPTH naturally. count is a separate LOG2_DEPTH+1-bit register and never exceeds DEPTH or goes below 0.
- flush has priority over push and pop: wr_ptr = rd_ptr = count = 0 at the next edge. A byte arriving in the flush cycle is dropped without setting overflow. flush does not touch the flags.
- clr_flags clears overflow and break_seen. If a set event (overflow drop or uart_rx_break) occurs in the same cycle, the set wins.
- irq is combinational from count and overflow; there is no pulse behaviour.

Test Plan:
- Reset then idle → rd_valid=0, count=0, rd_data=8'h00, irq=0. Push 8'h41 → next cycle rd_valid=1, rd_data=8'h41, irq=1. Pop → count=0.
- Push 8'h00..8'h0F (16 bytes) → full=1, count=16. Push 8'hAA → dropped, overflow=1. Pop all 16 → values 00..0F in order, and 8'hAA never appears.
- With full=1, pop and push 8'h55 in the same cycle → count stays 16, overflow=0, 8'h55 is the last byte popped. Then 40 push/pop cycles across wrap → data order preserved.
- Push and pop on empty in the same cycle with 8'h33 → count=1, rd_data=8'h33. Pop on empty → count stays 0, no flag set.
- uart_rx_break together with uart_rx_valid (8'h00) → break_seen=1, count unchanged. clr_flags together with a new break pulse → break_seen stays 1. clr_flags alone → break_seen=0.
- Queue 5 bytes, assert flush with a simultaneous push → count=0, overflow=0. Queue 3 bytes, assert rst_n=0 for one edge → count=0, all flags 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the mem_ctl UART register window.
// Show-ahead read port, sticky overflow/break status and a level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int LOG2_DEPTH    = 4,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  uart_rx_en,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_break,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [LOG2_DEPTH:0]   count,
  output logic                  overflow,
  output logic                  break_seen,
  output logic                  irq
);

  localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] IRQ_COUNT  = (LOG2_DEPTH+1)'(IRQ_THRESHOLD);

  logic [7:0]            mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  break_seen_q, break_seen_d;

  logic push_req;
  logic pop_eff;
  logic do_push;
  logic ovf_set;
  logic is_full;
  logic is_empty;

  assign is_full  = (count_q == FULL_COUNT);
  assign is_empty = (count_q == '0);

  always_comb begin
    push_req     = uart_rx_valid & enable & ~uart_rx_break & ~flush;
    pop_eff      = pop & ~is_empty & ~flush;
    // A simultaneous pop frees the slot, so a full FIFO can still accept
    do_push      = push_req & (~is_full | pop_eff);
    ovf_set      = push_req & is_full & ~pop_eff;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    break_seen_d = break_seen_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !pop_eff)      count_d = count_q + 1'b1;
      else if (!do_push && pop_eff) count_d = count_q - 1'b1;
    end

    if (clr_flags) begin
      overflow_d   = 1'b0;
      break_seen_d = 1'b0;
    end
    if (ovf_set)       overflow_d   = 1'b1;
    if (uart_rx_break) break_seen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      break_seen_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      break_seen_q <= break_seen_d;
    end
  end

  // Storage is deliberately left unreset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= uart_rx_data;
  end

  assign uart_rx_en = enable;
  assign rd_valid   = ~is_empty;
  assign rd_data    = is_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign full       = is_full;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign break_seen = break_seen_q;
  assign irq        = (count_q >= IRQ_COUNT) | overflow_q;

endmodule
